exc_pipe_stage: RTL

EXC_PIPE_STAGE -- requirements
Module: exc_pipe_stage

---
 rtl/exc_pipe_stage_pkg.sv | 29 ++
 rtl/exc_pipe_stage_prio_sel.sv | 44 ++++
 rtl/exc_pipe_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/exc_pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exc_pipe_stage_pkg
// Purpose : Shared CP0 definitions for the exception pipeline stages:
//           stage state encoding, default exception code width and the
//           MIPS exception code constants.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package exc_pipe_stage_pkg;

  localparam int CP0_CODE_W = 5;

  // Stage squash state: SQUASH kills younger instructions after an
  // exception or eret has been captured, until the redirect flush arrives.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } stage_state_t;

  localparam logic [CP0_CODE_W-1:0] c_EXC_ADEL = 5'h04;
  localparam logic [CP0_CODE_W-1:0] c_EXC_ADES = 5'h05;
  localparam logic [CP0_CODE_W-1:0] c_EXC_SYS  = 5'h08;
  localparam logic [CP0_CODE_W-1:0] c_EXC_BP   = 5'h09;
  localparam logic [CP0_CODE_W-1:0] c_EXC_RI   = 5'h0A;
  localparam logic [CP0_CODE_W-1:0] c_EXC_OV   = 5'h0C;

endpackage : exc_pipe_stage_pkg
`default_nettype wire

// File: rtl/exc_pipe_stage_prio_sel.sv
`default_nettype none
// ============================================================================
// Module  : exc_prio_sel
// Purpose : Purely combinational fixed-priority selector over local exception
//           sources. Index 0 has the highest priority.
// Ports   : i_src_exc      NUM_SRC request vector
//           i_src_code     packed codes, slice i belongs to request i
//           i_src_badvaddr packed 32-bit bad addresses
//           o_hit          any request set
//           o_code         code of winning request (0 when none)
//           o_badvaddr     bad address of winning request (0 when none)
// Rev     : 1.0  initial release
// ============================================================================
module exc_prio_sel
  import exc_pipe_stage_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = CP0_CODE_W
) (
  input  logic [NUM_SRC-1:0]        i_src_exc,
  input  logic [NUM_SRC*CODE_W-1:0] i_src_code,
  input  logic [NUM_SRC*32-1:0]     i_src_badvaddr,
  output logic                      o_hit,
  output logic [CODE_W-1:0]         o_code,
  output logic [31:0]               o_badvaddr
);

  // Scan from the highest index down so the lowest set index is the last
  // assignment and therefore wins.
  always_comb begin
    o_hit      = 1'b0;
    o_code     = '0;
    o_badvaddr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_src_exc[i]) begin
        o_hit      = 1'b1;
        o_code     = i_src_code[i*CODE_W +: CODE_W];
        o_badvaddr = i_src_badvaddr[i*32 +: 32];
      end
    end
  end

endmodule : exc_prio_sel
`default_nettype wire

// File: rtl/exc_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : exc_pipe_stage
// Purpose : One pipeline stage with valid/allowin handshake that merges an
//           upstream exception with locally detected ones, computes EPC,
//           squashes younger instructions after an exception/eret and,
//           as the commit stage, raises commit pulses.
// Ports   : clk/resetn                        clock, async active-low reset
//           in_valid/allowin                   upstream handshake
//           out_valid/out_allowin              downstream handshake
//           stall, flush                       hold / redirect flush
//           in_* / src_* / loc_is_eret         incoming instruction info
//           out_*                              registered instruction info
//           squashing                          stage is killing younger instrs
//           commit_exc/commit_eret             commit pulses (COMMIT=1 only)
// Rev     : 1.0  initial release
// ============================================================================
module exc_pipe_stage
  import exc_pipe_stage_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int PAYLOAD_W = 32,
  parameter int CODE_W    = CP0_CODE_W,
  parameter bit COMMIT    = 1'b0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  input  logic                      out_allowin,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_badvaddr,
  input  logic [CODE_W-1:0]         in_exccode,
  input  logic                      in_is_exc,
  input  logic                      in_is_in_ds,
  input  logic                      in_is_eret,
  input  logic [NUM_SRC-1:0]        src_exc,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
  input  logic [NUM_SRC*32-1:0]     src_badvaddr,
  input  logic                      loc_is_eret,
  output logic                      allowin,
  output logic                      out_valid,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_epc,
  output logic [31:0]               out_badvaddr,
  output logic [CODE_W-1:0]         out_exccode,
  output logic                      out_is_exc,
  output logic                      out_is_in_ds,
  output logic                      out_is_eret,
  output logic                      squashing,
  output logic                      commit_exc,
  output logic                      commit_eret
);

  stage_state_t           r_state;
  logic                   r_valid;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [31:0]            r_pc;
  logic [31:0]            r_epc;
  logic [31:0]            r_badvaddr;
  logic [CODE_W-1:0]      r_exccode;
  logic                   r_is_exc;
  logic                   r_is_in_ds;
  logic                   r_is_eret;

  logic                   w_sel_hit;
  logic [CODE_W-1:0]      w_sel_code;
  logic [31:0]            w_sel_badvaddr;
  logic                   w_exc;
  logic [CODE_W-1:0]      w_code;
  logic [31:0]            w_badvaddr;
  logic                   w_eret;
  logic [31:0]            w_epc;
  logic                   w_ready_go;

  exc_prio_sel #(
    .NUM_SRC (NUM_SRC),
    .CODE_W  (CODE_W)
  ) u_prio_sel (
    .i_src_exc      (src_exc),
    .i_src_code     (src_code),
    .i_src_badvaddr (src_badvaddr),
    .o_hit          (w_sel_hit),
    .o_code         (w_sel_code),
    .o_badvaddr     (w_sel_badvaddr)
  );

  // Upstream exception is older than anything detected here, so it wins.
  // The selector already returns zeros when nothing is pending.
  assign w_exc      = in_is_exc | w_sel_hit;
  assign w_code     = in_is_exc ? in_exccode  : w_sel_code;
  assign w_badvaddr = in_is_exc ? in_badvaddr : w_sel_badvaddr;
  assign w_eret     = (in_is_eret | loc_is_eret) & ~w_exc;
  assign w_epc      = in_is_in_ds ? (in_pc - 32'd4) : in_pc;

  assign w_ready_go = ~stall;
  assign allowin    = ~r_valid | (w_ready_go & out_allowin);
  assign out_valid  = r_valid & w_ready_go;
  assign squashing  = (r_state == ST_SQUASH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_RUN;
      r_valid    <= 1'b0;
      r_payload  <= '0;
      r_pc       <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_exccode  <= '0;
      r_is_exc   <= 1'b0;
      r_is_in_ds <= 1'b0;
      r_is_eret  <= 1'b0;
    end else if (flush) begin
      // Redirect overrides any capture on the same edge; data regs hold.
      r_state <= ST_RUN;
      r_valid <= 1'b0;
    end else if (allowin) begin
      // In SQUASH the handshake still completes but the instruction dies.
      r_valid <= in_valid & (r_state == ST_RUN);
      if (in_valid) begin
        r_payload  <= in_payload;
        r_pc       <= in_pc;
        r_epc      <= w_epc;
        r_badvaddr <= w_badvaddr;
        r_exccode  <= w_code;
        r_is_exc   <= w_exc;
        r_is_in_ds <= in_is_in_ds;
        r_is_eret  <= w_eret;
        if (r_state == ST_RUN && (w_exc || w_eret)) begin
          r_state <= ST_SQUASH;
        end
      end
    end
  end

  assign out_payload  = r_payload;
  assign out_pc       = r_pc;
  assign out_epc      = r_epc;
  assign out_badvaddr = r_badvaddr;
  assign out_exccode  = r_exccode;
  assign out_is_exc   = r_is_exc;
  assign out_is_in_ds = r_is_in_ds;
  assign out_is_eret  = r_is_eret;

  generate
    if (COMMIT) begin : g_commit
      assign commit_exc  = out_valid & r_is_exc  & out_allowin;
      assign commit_eret = out_valid & r_is_eret & out_allowin;
    end else begin : g_no_commit
      assign commit_exc  = 1'b0;
      assign commit_eret = 1'b0;
    end
  endgenerate

endmodule : exc_pipe_stage
`default_nettype wire
